// File: rtl/register_64.sv
// Width-parameterised register: per-bit enable mux into a sync-clear DFF.
// REGISTER_64_GATE_DELAY_EN adds #DELAY to every internal mux gate.
`timescale 1ns/10ps
module register_64 #(
  parameter int  WIDTH = 64,
  parameter real DELAY = 0.05
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || DELAY < 0.0) begin : g_bad_cfg
    $error("register_64: WIDTH must be > 0 and DELAY >= 0");
  end

  logic en_n;
`ifdef REGISTER_64_GATE_DELAY_EN
  assign #(DELAY) en_n = ~en;
`else
  assign en_n = ~en;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic hold;
    logic load;
    logic nxt;

`ifdef REGISTER_64_GATE_DELAY_EN
    assign #(DELAY) hold = q[i] & en_n;
    assign #(DELAY) load = d[i] & en;
    assign #(DELAY) nxt  = hold | load;
`else
    assign hold = q[i] & en_n;
    assign load = d[i] & en;
    assign nxt  = hold | load;
`endif

    // Ternary keeps an unknown reset visible as X rather than picking a branch.
    always_ff @(posedge clk) begin
      q[i] <= reset ? nxt : 1'b0;
    end
  end

endmodule

// File: tb/tb_register_64.sv
// Self-checking bench for register_64: vector table, corner sequences,
// and randomized traffic against a behavioural model.
`timescale 1ns/10ps
module tb_register_64;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic         en;
  logic [W-1:0] d;
  logic [W-1:0] q;

  int compared = 0;
  int mismatched = 0;

  register_64 #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .d    (d),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         reset;
    logic         en;
    logic [W-1:0] d;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [W-1:0] exp);
    compared++;
    if (q !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, q, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [W-1:0] dd);
    @(negedge clk);
    reset = r;
    en    = e;
    d     = dd;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] model;
  logic [W-1:0] rd;
  logic         rr;
  logic         re;

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    d     = '0;

    vt.push_back('{1'b0, 1'b0, 64'h0, 64'h0, "reset"});
    vt.push_back('{1'b1, 1'b0, 64'h0, 64'h0, "release_hold0"});
    vt.push_back('{1'b1, 1'b1, 64'd128, 64'd128, "load128"});
    vt.push_back('{1'b1, 1'b0, 64'h0, 64'd128, "hold1"});
    vt.push_back('{1'b1, 1'b0, 64'h0, 64'd128, "hold2"});
    vt.push_back('{1'b1, 1'b1, 64'h0, 64'h0, "load0"});
    vt.push_back('{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFF, "load_ones"});
    vt.push_back('{1'b0, 1'b1, 64'h1234, 64'h0, "reset_over_en"});
    vt.push_back('{1'b1, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA,
                   64'hAAAA_AAAA_AAAA_AAAA, "load_aa"});
    vt.push_back('{1'b1, 1'b1, 64'h5555_5555_5555_5555,
                   64'h5555_5555_5555_5555, "load_55"});
    vt.push_back('{1'b1, 1'b1, 64'h8000_0000_0000_0001,
                   64'h8000_0000_0000_0001, "load_edges"});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].reset, vt[i].en, vt[i].d);
      check(vt[i].name, vt[i].exp);
    end

    // Reset glitch between edges with en low leaves q alone.
    step(1'b1, 1'b1, 64'hDEAD_BEEF_0000_1111);
    check("glitch_pre", 64'hDEAD_BEEF_0000_1111);
    @(negedge clk);
    en = 1'b0;
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1 check("glitch_reset", 64'hDEAD_BEEF_0000_1111);

    // Inputs changing mid-cycle must not reach q before the edge.
    @(negedge clk);
    en = 1'b1;
    d  = 64'h0123_4567_89AB_CDEF;
    #2 check("no_comb_path", 64'hDEAD_BEEF_0000_1111);
    reset = 1'b0;
    #1 check("no_comb_reset", 64'hDEAD_BEEF_0000_1111);
    @(posedge clk);
    #1 check("reset_edge", 64'h0);

    // Reset held low acts as a constant-zero register.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, {$urandom, $urandom} | 64'h1);
      check("zero_reg", 64'h0);
    end

    // Randomized traffic against the behavioural model.
    model = 64'h0;
    for (int i = 0; i < 300; i++) begin
      rr = ($urandom_range(0, 9) != 0);
      re = $urandom_range(0, 1) == 1;
      rd = {$urandom, $urandom};
      step(rr, re, rd);
      if (!rr)
        model = 64'h0;
      else if (re)
        model = rd;
      check("random", model);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
